// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA capture path.
//   - default 640x480@60 timing constants (overridable per instance)
//   - lock FSM state encoding
//   - coordinate width, shared with the driver's address ports
//   - saturating counter increment helper
package vga_pkg;

    localparam int COORD_W = 12;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL_DEF  = 525;
    localparam bit SYNC_POL_DEF = 1'b0;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_e;

    // Counters stick at all-ones rather than wrapping, so a missing sync
    // can never alias back into a plausible coordinate.
    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == {COORD_W{1'b1}}) ? v : v + COORD_W'(1);
    endfunction

endpackage

// File: rtl/vga_capture_sync_edge_det.sv
// sync_edge_det: two-stage sync register with polarity normalisation and
// leading-edge detection.
//   clk_i   pixel clock
//   rst_i   synchronous reset, active-high
//   sync_i  raw sync pin (active level set by SYNC_POL)
//   edge_o  one-cycle pulse while the newest sample is the first active one
module sync_edge_det
    import vga_pkg::*;
#(
    parameter bit SYNC_POL = SYNC_POL_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic edge_o
);

    logic s1_d;
    logic s1_q;
    logic s2_q;

    // Normalise to active-high so everything downstream is polarity-free.
    assign s1_d = SYNC_POL ? sync_i : ~sync_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s1_q;
        end
    end

    assign edge_o = s1_q & ~s2_q;

endmodule

// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA link. Recovers pixel coordinates and
// data from an h_sync/v_sync/rgb stream, checks its timing against the
// configured mode and only emits pixels once the timing is locked.
//   clk_i, rst_i               pixel clock, synchronous active-high reset
//   h_sync_i, v_sync_i         sync pins (active level = SYNC_POL)
//   rgb_r_i/rgb_g_i/rgb_b_i    pixel colour, one pixel per clock
//   pix_valid_o                active, locked pixel on pix_* this cycle
//   pix_x_o, pix_y_o           pixel coordinates (hold while not valid)
//   pix_data_o                 {r,g,b}
//   frame_start_o              pulse with pixel (0,0)
//   locked_o                   incoming timing matches the mode
//   timing_err_o               pulse when lock is lost
// Pins reach pix_* three cycles later: s1 register, counters, output register.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               h_sync_i,
    input  logic               v_sync_i,
    input  logic [7:0]         rgb_r_i,
    input  logic [7:0]         rgb_g_i,
    input  logic [7:0]         rgb_b_i,
    output logic               pix_valid_o,
    output logic [COORD_W-1:0] pix_x_o,
    output logic [COORD_W-1:0] pix_y_o,
    output logic [23:0]        pix_data_o,
    output logic               frame_start_o,
    output logic               locked_o,
    output logic               timing_err_o
);

    localparam logic [COORD_W-1:0] H_START   = COORD_W'(H_SYNC + H_BACK);
    localparam logic [COORD_W-1:0] H_END     = COORD_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [COORD_W-1:0] V_START   = COORD_W'(V_SYNC + V_BACK);
    localparam logic [COORD_W-1:0] V_END     = COORD_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [COORD_W:0]   LINE_OK   = (COORD_W+1)'(H_TOTAL);
    localparam logic [COORD_W:0]   FRAME_OK  = (COORD_W+1)'(V_TOTAL);
    // p reaching 2*H_TOTAL without an edge means the sync has gone away.
    localparam logic [COORD_W-1:0] TIMEOUT_P = COORD_W'(2 * H_TOTAL - 1);

    // ---------------- input pipe ----------------
    logic        hs_edge;
    logic        vs_edge;
    logic [23:0] rgb_s1_q;
    logic [23:0] rgb_s2_q;

    sync_edge_det #(.SYNC_POL(SYNC_POL)) u_hs_det (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sync_i (h_sync_i),
        .edge_o (hs_edge)
    );

    sync_edge_det #(.SYNC_POL(SYNC_POL)) u_vs_det (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sync_i (v_sync_i),
        .edge_o (vs_edge)
    );

    // ---------------- position counters ----------------
    logic [COORD_W-1:0] p_q, p_d;
    logic [COORD_W-1:0] l_q, l_d;
    logic               pend_q, pend_d;
    logic [COORD_W:0]   line_len;
    logic [COORD_W:0]   frame_lines;
    logic               fs_evt;
    logic               line_ok;
    logic               frame_ok;
    logic               timeout;

    // Lengths are taken from the counters before they restart, i.e. of the
    // line/frame that this edge just finished.
    assign line_len    = {1'b0, p_q} + (COORD_W+1)'(1);
    assign frame_lines = {1'b0, l_q} + (COORD_W+1)'(1);
    assign line_ok     = (line_len == LINE_OK);
    assign frame_ok    = (frame_lines == FRAME_OK);
    // A vsync edge arms frame start; the hsync edge that follows (or the
    // coincident one) is line 0.
    assign fs_evt      = hs_edge & (pend_q | vs_edge);
    assign timeout     = ~hs_edge & (p_q == TIMEOUT_P);

    always_comb begin
        p_d    = hs_edge ? '0 : sat_inc(p_q);
        l_d    = l_q;
        pend_d = pend_q | vs_edge;
        if (hs_edge) begin
            if (fs_evt) begin
                l_d    = '0;
                pend_d = 1'b0;
            end else begin
                l_d = sat_inc(l_q);
            end
        end
    end

    // ---------------- lock FSM ----------------
    lock_state_e state_q, state_d;
    logic        mism_q, mism_d;
    logic        skip_q, skip_d;
    logic        line_bad_m;

    // The line ending at the first edge after entering MEASURE is not judged.
    assign line_bad_m = hs_edge & ~line_ok & ~skip_q;

    always_comb begin
        state_d = state_q;
        mism_d  = mism_q;
        skip_d  = skip_q;
        if (hs_edge) skip_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (fs_evt) begin
                    state_d = MEASURE;
                    mism_d  = 1'b0;
                    skip_d  = 1'b1;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    state_d = SEARCH;
                end else begin
                    if (line_bad_m) mism_d = 1'b1;
                    if (fs_evt) begin
                        if (!mism_q && !line_bad_m && frame_ok) state_d = LOCKED;
                        mism_d = 1'b0;
                    end
                end
            end
            LOCKED: begin
                if (timeout || (hs_edge && !line_ok) || (fs_evt && !frame_ok))
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    // ---------------- output stage ----------------
    logic               active;
    logic               act_lock;
    logic [COORD_W-1:0] x_cur;
    logic [COORD_W-1:0] y_cur;
    logic [COORD_W-1:0] pix_x_q, pix_x_d;
    logic [COORD_W-1:0] pix_y_q, pix_y_d;
    logic [23:0]        pix_data_q, pix_data_d;
    logic               pix_valid_q;
    logic               frame_start_q;
    logic               locked_q;
    logic               timing_err_q;

    assign active   = (p_q >= H_START) && (p_q < H_END) &&
                      (l_q >= V_START) && (l_q < V_END);
    assign act_lock = active && (state_q == LOCKED);
    assign x_cur    = p_q - H_START;
    assign y_cur    = l_q - V_START;

    always_comb begin
        pix_x_d    = pix_x_q;
        pix_y_d    = pix_y_q;
        pix_data_d = pix_data_q;
        if (act_lock) begin
            pix_x_d    = x_cur;
            pix_y_d    = y_cur;
            pix_data_d = rgb_s2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_s1_q      <= '0;
            rgb_s2_q      <= '0;
            p_q           <= '0;
            l_q           <= '0;
            pend_q        <= 1'b0;
            state_q       <= SEARCH;
            mism_q        <= 1'b0;
            skip_q        <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            rgb_s1_q      <= {rgb_r_i, rgb_g_i, rgb_b_i};
            rgb_s2_q      <= rgb_s1_q;
            p_q           <= p_d;
            l_q           <= l_d;
            pend_q        <= pend_d;
            state_q       <= state_d;
            mism_q        <= mism_d;
            skip_q        <= skip_d;
            pix_valid_q   <= act_lock;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= act_lock && (x_cur == '0) && (y_cur == '0);
            locked_q      <= (state_d == LOCKED);
            timing_err_q  <= (state_q == LOCKED) && (state_d != LOCKED);
        end
    end

    assign pix_valid_o   = pix_valid_q;
    assign pix_x_o       = pix_x_q;
    assign pix_y_o       = pix_y_q;
    assign pix_data_o    = pix_data_q;
    assign frame_start_o = frame_start_q;
    assign locked_o      = locked_q;
    assign timing_err_o  = timing_err_q;

endmodule
